// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - address and ASID types shared across the CPU
package cpu_types_pkg;
  localparam int VA_W   = 32;
  localparam int PA_W   = 32;
  localparam int ASID_W = 8;

  typedef logic [VA_W-1:0]   virtual_address_t;
  typedef logic [PA_W-1:0]   physical_address_t;
  typedef logic [ASID_W-1:0] asid_t;
endpackage

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - page-table entry, TLB entry, walker states and fault causes
package mmu_pkg;
  import cpu_types_pkg::*;

  localparam int PAGE_BITS = 13;
  localparam int PPN_W     = PA_W - PAGE_BITS;
  localparam int VPN_W     = VA_W - PAGE_BITS;

  // PPN sits at its physical bit position so a PDE/PTE reads like an address
  typedef struct packed {
    logic [31:0]      rsvd_hi;
    logic [PPN_W-1:0] ppn;
    logic [8:0]       rsvd_lo;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } pte_t;

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
    asid_t            asid;
    pte_t             pte;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1,
    ST_L0,
    ST_WRITE,
    ST_FAULT,
    ST_SETTLE
  } walk_state_e;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] PF_L1   = 3'd1;
  localparam logic [2:0] PF_L0   = 3'd2;
  localparam logic [2:0] BERR    = 3'd3;
  localparam logic [2:0] TMO     = 3'd4;
endpackage

// File: rtl/rr_way_sel.sv
// rtl/rr_way_sel.sv - modulo-N round-robin way counter with advance enable
module rr_way_sel #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] way
);
  logic [W-1:0] way_q, way_d;

  always_comb begin
    way_d = way_q;
    if (adv) way_d = (way_q == W'(N - 1)) ? '0 : way_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) way_q <= '0;
    else     way_q <= way_d;
  end

  assign way = way_q;
endmodule

// File: rtl/tlb_miss_walker.sv
// rtl/tlb_miss_walker.sv - two-level page-table walker servicing TLB misses
// over a classic Wishbone read port; fills a round-robin TLB way or faults.
module tlb_miss_walker
  import cpu_types_pkg::*;
  import mmu_pkg::*;
#(
  parameter int TLB_ASSOC    = 3,
  parameter int LOG_PAGESIZE = 13,
  parameter int TIMEOUT      = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         paging_en,
  input  physical_address_t            ptbr,
  input  logic                         miss_v,
  input  virtual_address_t             miss_adr,
  input  asid_t                        miss_asid,
  input  logic [7:0]                   miss_id,
  output logic                         busy,
  output logic                         wb_cyc,
  output logic                         wb_stb,
  output physical_address_t            wb_adr,
  input  logic                         wb_ack,
  input  logic                         wb_err,
  input  logic [63:0]                  wb_dat_i,
  output logic                         tlb_wr,
  output logic [$clog2(TLB_ASSOC)-1:0] tlb_way,
  output tlb_entry_t                   tlb_wr_entry,
  output logic                         fault_v,
  output virtual_address_t             fault_adr,
  output logic [7:0]                   fault_id,
  output logic [2:0]                   fault_cause
);
  localparam int WAY_W  = $clog2(TLB_ASSOC);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int L1_LSB = LOG_PAGESIZE + 10;

  walk_state_e       state_q, state_d;
  virtual_address_t  va_q, va_d;
  asid_t             asid_q, asid_d;
  logic [7:0]        id_q, id_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              cyc_q, cyc_d;
  physical_address_t adr_q, adr_d;
  logic              wr_q, wr_d;
  logic [WAY_W-1:0]  way_q, way_d;
  tlb_entry_t        entry_q, entry_d;
  logic              fv_q, fv_d;
  virtual_address_t  fadr_q, fadr_d;
  logic [7:0]        fid_q, fid_d;
  logic [2:0]        fcause_q, fcause_d;

  pte_t             rd_pte;
  logic [2:0]       cause;
  logic             timed_out;
  logic             done;
  logic             rr_adv;
  logic [WAY_W-1:0] rr_way;

  rr_way_sel #(.N(TLB_ASSOC), .W(WAY_W)) u_rr (
    .clk (clk),
    .rst (rst),
    .adv (rr_adv),
    .way (rr_way)
  );

  always_comb begin
    state_d  = state_q;
    va_d     = va_q;
    asid_d   = asid_q;
    id_d     = id_q;
    abort_d  = abort_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    wr_d     = 1'b0;
    way_d    = way_q;
    entry_d  = entry_q;
    fv_d     = 1'b0;
    fadr_d   = fadr_q;
    fid_d    = fid_q;
    fcause_d = fcause_q;
    rr_adv   = 1'b0;
    rd_pte   = pte_t'(wb_dat_i);
    timed_out = (wait_q == CNT_W'(TIMEOUT - 1));
    done      = wb_err | wb_ack | timed_out;
    // err outranks a simultaneous ack
    cause = FC_NONE;
    if (wb_err)         cause = BERR;
    else if (wb_ack)    cause = rd_pte.v ? FC_NONE : ((state_q == ST_L1) ? PF_L1 : PF_L0);
    else if (timed_out) cause = TMO;

    case (state_q)
      ST_IDLE: begin
        if (miss_v && paging_en) begin
          va_d    = miss_adr;
          asid_d  = miss_asid;
          id_d    = miss_id;
          abort_d = 1'b0;
          wait_d  = '0;
          cyc_d   = 1'b1;
          adr_d   = ptbr + physical_address_t'({miss_adr[VA_W-1:L1_LSB], 3'b000});
          state_d = ST_L1;
        end
      end
      ST_L1, ST_L0: begin
        if (!paging_en) abort_d = 1'b1;
        if (!done) begin
          wait_d = wait_q + 1'b1;
        end else begin
          cyc_d  = 1'b0;
          wait_d = '0;
          // a disable seen at any point of the walk cancels it once the bus is free
          if (abort_q || !paging_en) begin
            state_d = ST_IDLE;
          end else if (cause != FC_NONE) begin
            fv_d     = 1'b1;
            fadr_d   = va_q;
            fid_d    = id_q;
            fcause_d = cause;
            state_d  = ST_FAULT;
          end else if (state_q == ST_L1) begin
            cyc_d   = 1'b1;
            adr_d   = {rd_pte.ppn, va_q[L1_LSB-1:LOG_PAGESIZE], 3'b000};
            state_d = ST_L0;
          end else begin
            wr_d          = 1'b1;
            way_d         = rr_way;
            entry_d.vpn   = va_q[VA_W-1:LOG_PAGESIZE];
            entry_d.asid  = asid_q;
            entry_d.pte   = rd_pte;
            rr_adv        = 1'b1;
            state_d       = ST_WRITE;
          end
        end
      end
      ST_WRITE, ST_FAULT: begin
        settle_d = 1'b0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q) state_d = ST_IDLE;
        else          settle_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      va_q     <= '0;
      asid_q   <= '0;
      id_q     <= '0;
      abort_q  <= 1'b0;
      wait_q   <= '0;
      settle_q <= 1'b0;
      busy_q   <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      wr_q     <= 1'b0;
      way_q    <= '0;
      entry_q  <= '0;
      fv_q     <= 1'b0;
      fadr_q   <= '0;
      fid_q    <= '0;
      fcause_q <= '0;
    end else begin
      state_q  <= state_d;
      va_q     <= va_d;
      asid_q   <= asid_d;
      id_q     <= id_d;
      abort_q  <= abort_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      wr_q     <= wr_d;
      way_q    <= way_d;
      entry_q  <= entry_d;
      fv_q     <= fv_d;
      fadr_q   <= fadr_d;
      fid_q    <= fid_d;
      fcause_q <= fcause_d;
    end
  end

  assign busy         = busy_q;
  assign wb_cyc       = cyc_q;
  assign wb_stb       = cyc_q;
  assign wb_adr       = adr_q;
  assign tlb_wr       = wr_q;
  assign tlb_way      = way_q;
  assign tlb_wr_entry = entry_q;
  assign fault_v      = fv_q;
  assign fault_adr    = fadr_q;
  assign fault_id     = fid_q;
  assign fault_cause  = fcause_q;
endmodule

// File: tb/tb_tlb_miss_walker.sv
// tb/tb_tlb_miss_walker.sv - scoreboard bench for tlb_miss_walker
module tb_tlb_miss_walker;
  import cpu_types_pkg::*;
  import mmu_pkg::*;

  logic              clk = 1'b0, rst = 1'b1, paging_en = 1'b0, miss_v = 1'b0;
  physical_address_t ptbr = 32'h0010_0000;
  virtual_address_t  miss_adr = '0;
  asid_t             miss_asid = '0;
  logic [7:0]        miss_id = '0;
  logic              wb_ack = 1'b0, wb_err = 1'b0;
  logic [63:0]       wb_dat_i = '0;
  logic              busy, wb_cyc, wb_stb, tlb_wr, fault_v;
  physical_address_t wb_adr;
  logic [1:0]        tlb_way;
  tlb_entry_t        tlb_wr_entry;
  virtual_address_t  fault_adr;
  logic [7:0]        fault_id;
  logic [2:0]        fault_cause;

  typedef struct {
    bit               is_fault;
    bit               chk_lat;
    logic [1:0]       way;
    logic [18:0]      vpn;
    asid_t            asid;
    logic [63:0]      pte;
    logic [2:0]       cause;
    virtual_address_t fadr;
    logic [7:0]       fid;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem [logic [31:0]];
  logic [31:0] adr_log[$];
  logic [31:0] stall_at = '1, err_at = '1;
  int          total = 0, bad = 0, cnt = 0, t0 = 0, cyc_hi = 0;
  logic [1:0]  rr_m = '0;

  tlb_miss_walker dut (
    .clk(clk), .rst(rst), .paging_en(paging_en), .ptbr(ptbr),
    .miss_v(miss_v), .miss_adr(miss_adr), .miss_asid(miss_asid), .miss_id(miss_id),
    .busy(busy), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_i(wb_dat_i),
    .tlb_wr(tlb_wr), .tlb_way(tlb_way), .tlb_wr_entry(tlb_wr_entry),
    .fault_v(fault_v), .fault_adr(fault_adr), .fault_id(fault_id), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_pte(input logic [18:0] ppn);
    return {32'h0, ppn, 9'h0, 3'b111, 1'b1};
  endfunction

  function automatic virtual_address_t walk_va(input int i);
    return 32'h0080_4123 + 32'(i) * 32'h2000;
  endfunction

  // bus slave: decides the response half a cycle after the DUT's edge
  always @(negedge clk) begin
    #1;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    if (wb_cyc && !rst) begin
      if (wb_adr == err_at) begin
        wb_err = 1'b1; wb_ack = 1'b1;
        wb_dat_i = mem.exists(wb_adr) ? mem[wb_adr] : 64'h0;
      end else if (wb_adr != stall_at) begin
        wb_ack = 1'b1;
        wb_dat_i = mem.exists(wb_adr) ? mem[wb_adr] : 64'h0;
        adr_log.push_back(wb_adr);
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (wb_cyc) cyc_hi++;
      if (wb_stb !== wb_cyc) chk("stb_eq_cyc", wb_stb, wb_cyc);
      if (tlb_wr && fault_v) chk("wr_fault_excl", fault_v, 0);
      if (tlb_wr || fault_v) begin
        if (sb.size() == 0) begin
          chk("spurious_evt", {tlb_wr, fault_v}, 0);
        end else begin
          e = sb.pop_front();
          chk("evt_kind", fault_v, e.is_fault);
          if (e.is_fault) begin
            chk("f_cause", fault_cause, e.cause);
            chk("f_adr", fault_adr, e.fadr);
            chk("f_id", fault_id, e.fid);
            chk("f_cyc_low", wb_cyc, 0);
          end else begin
            chk("wr_way", tlb_way, e.way);
            chk("wr_vpn", tlb_wr_entry.vpn, e.vpn);
            chk("wr_asid", tlb_wr_entry.asid, e.asid);
            chk("wr_pte", tlb_wr_entry.pte, e.pte);
            if (e.chk_lat) chk("wr_cycle", cnt - t0, 3);
          end
        end
      end
    end
  end

  task automatic expect_wr(input int i, input asid_t asid, input bit lat);
    exp_t e;
    e = '{default: '0};
    e.chk_lat = lat;
    e.way = rr_m;
    e.vpn = 19'(walk_va(i) >> 13);
    e.asid = asid;
    e.pte = mk_pte(19'h1234 + 19'(i));
    sb.push_back(e);
    rr_m = (rr_m == 2'd2) ? 2'd0 : rr_m + 2'd1;
  endtask

  task automatic expect_fault(input logic [2:0] cause, input virtual_address_t va, input logic [7:0] id);
    exp_t e;
    e = '{default: '0};
    e.is_fault = 1'b1;
    e.cause = cause;
    e.fadr = va;
    e.fid = id;
    sb.push_back(e);
  endtask

  task automatic start_miss(input virtual_address_t va, input asid_t asid, input logic [7:0] id);
    @(negedge clk);
    miss_v = 1'b1; miss_adr = va; miss_asid = asid; miss_id = id;
    t0 = cnt; cyc_hi = 0;
    @(negedge clk);
    miss_v = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, wb_cyc, wb_stb, tlb_wr, fault_v, tlb_way, fault_cause}, 0);
    chk({tag, "_adr"}, wb_adr, 0);
    chk({tag, "_entry"}, tlb_wr_entry, 0);
    chk({tag, "_fault"}, {fault_adr, fault_id}, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[32'h0040_0010 + 32'(8 * i)] = mk_pte(19'h1234 + 19'(i));
    mem[32'h0010_0008] = 64'h0000_0000_0040_0001;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    paging_en = 1'b1;

    adr_log.delete();
    expect_wr(0, 8'd5, 1'b1);
    start_miss(walk_va(0), 8'd5, 8'd7);
    repeat (4) @(negedge clk);
    chk("busy_cycle5", busy, 1);
    @(negedge clk);
    chk("busy_cycle6", busy, 0);
    chk("bus_reads", adr_log.size(), 2);
    if (adr_log.size() >= 2) begin
      chk("l1_adr", adr_log[0], 32'h0010_0008);
      chk("l0_adr", adr_log[1], 32'h0040_0010);
    end
    chk("basic_sb_empty", sb.size(), 0);

    for (int i = 1; i <= 3; i++) begin
      expect_wr(i, asid_t'(i + 1), 1'b0);
      start_miss(walk_va(i), asid_t'(i + 1), 8'(i));
      wait_idle("rotate");
    end

    mem[32'h0010_0008] = 64'h0;
    expect_fault(3'd1, walk_va(0), 8'd7);
    start_miss(walk_va(0), 8'd5, 8'd7);
    wait_idle("pf_l1");
    mem[32'h0010_0008] = 64'h0000_0000_0040_0001;

    err_at = 32'h0040_0010;
    expect_fault(3'd3, walk_va(0), 8'd9);
    start_miss(walk_va(0), 8'd5, 8'd9);
    wait_idle("berr");
    err_at = '1;

    stall_at = 32'h0010_0008;
    expect_fault(3'd4, walk_va(1), 8'd3);
    start_miss(walk_va(1), 8'd2, 8'd3);
    wait_idle("tmo");
    chk("tmo_cycles", cyc_hi, 1023);
    stall_at = '1;
    expect_wr(2, 8'd4, 1'b0);
    start_miss(walk_va(2), 8'd4, 8'd2);
    wait_idle("after_tmo");

    stall_at = 32'h0010_0008;
    start_miss(walk_va(3), 8'd6, 8'd4);
    paging_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_cyc_held", wb_cyc, 1);
    stall_at = '1;
    wait_idle("disable");
    paging_en = 1'b1;

    stall_at = 32'h0040_0030;
    start_miss(walk_va(4), 8'd8, 8'd5);
    for (int n = 0; n < 50 && wb_adr != 32'h0040_0030; n++) @(negedge clk);
    chk("reach_l0", wb_adr, 32'h0040_0030);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    rst = 1'b0;
    stall_at = '1;
    rr_m = '0;
    expect_wr(5, 8'd3, 1'b0);
    start_miss(walk_va(5), 8'd3, 8'd6);
    wait_idle("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
